// File: rtl/display_scheduler_if.sv
// Requester/display bundle shared between the display scheduler and its clients.
// The master side drives requests and digit codes; the slave side (the scheduler) returns grants and scan outputs.
interface display_scheduler_if;
  logic        alu_req;
  logic [39:0] alu_codes;
  logic        temp_req;
  logic [39:0] temp_codes;
  logic        alu_gnt;
  logic        temp_gnt;
  logic [4:0]  digit_code;
  logic [7:0]  anode;
  logic        frame_tick;

  modport master (
    output alu_req, alu_codes, temp_req, temp_codes,
    input  alu_gnt, temp_gnt, digit_code, anode, frame_tick
  );

  modport slave (
    input  alu_req, alu_codes, temp_req, temp_codes,
    output alu_gnt, temp_gnt, digit_code, anode, frame_tick
  );
endinterface

// File: rtl/display_scheduler.sv
// Scans an 8-digit seven-segment display and arbitrates it between the ALU and temperature paths.
// Ownership changes and code snapshots happen only on frame boundaries, so a frame never mixes sources.
module display_scheduler #(
  parameter int CLK_DIV     = 100000,
  parameter int HOLD_FRAMES = 256
) (
  input  logic                clock,
  input  logic                reset_n,
  display_scheduler_if.slave  bus
);
  localparam int PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALU,
    ST_TEMP
  } state_t;

  logic [PRE_W-1:0]  prescaler_reg, prescaler_next;
  logic [2:0]        index_reg, index_next;
  state_t            state_reg, state_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic [39:0]       snapshot_reg, snapshot_next;
  logic [7:0]        anode_reg, anode_next;
  logic [4:0]        digit_code_reg, digit_code_next;
  logic              frame_tick_reg;

  logic              slot_tick;
  logic              boundary;
  logic [HOLD_W-1:0] frames_done;
  logic              hold_expired;
  logic [4:0]        frame_digits [8];

  assign slot_tick = (prescaler_reg == PRE_LAST);
  assign boundary  = slot_tick && (index_reg == 3'd7);

  // hold_reg counts frames finished before this boundary; the frame ending now also counts,
  // so a grantee is released at the end of its HOLD_FRAMES-th full frame.
  assign frames_done  = (hold_reg == HOLD_MAX) ? HOLD_MAX : hold_reg + HOLD_ONE;
  assign hold_expired = (frames_done >= HOLD_MAX);

  always_comb begin
    state_next = state_reg;
    if (boundary) begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.alu_req)       state_next = ST_ALU;
          else if (bus.temp_req) state_next = ST_TEMP;
        end
        ST_ALU: begin
          if (hold_expired) begin
            if (bus.temp_req)     state_next = ST_TEMP;
            else if (!bus.alu_req) state_next = ST_IDLE;
          end
        end
        ST_TEMP: begin
          if (hold_expired) begin
            if (bus.alu_req)       state_next = ST_ALU;
            else if (!bus.temp_req) state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    hold_next      = hold_reg;
    snapshot_next  = snapshot_reg;
    prescaler_next = prescaler_reg + PRE_ONE;
    index_next     = index_reg;
    if (slot_tick) begin
      prescaler_next = '0;
      index_next     = index_reg + 3'd1;
    end
    if (boundary) begin
      hold_next = (state_next != state_reg) ? '0 : frames_done;
      case (state_next)
        ST_ALU:  snapshot_next = bus.alu_codes;
        ST_TEMP: snapshot_next = bus.temp_codes;
        default: snapshot_next = '0;
      endcase
    end
  end

  // The new frame's first digit reads the freshly latched snapshot, not the stale one.
  for (genvar gi = 0; gi < 8; gi++) begin : g_digits
    assign frame_digits[gi] = snapshot_next[5*gi +: 5];
  end

  always_comb begin
    anode_next      = anode_reg;
    digit_code_next = digit_code_reg;
    if (slot_tick) begin
      if (state_next == ST_IDLE) begin
        anode_next      = 8'hFF;
        digit_code_next = 5'd0;
      end else begin
        anode_next      = ~(8'h01 << index_next);
        digit_code_next = frame_digits[index_next];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prescaler_reg  <= '0;
      index_reg      <= 3'd0;
      state_reg      <= ST_IDLE;
      hold_reg       <= '0;
      snapshot_reg   <= '0;
      anode_reg      <= 8'hFF;
      digit_code_reg <= 5'd0;
      frame_tick_reg <= 1'b0;
    end else begin
      prescaler_reg  <= prescaler_next;
      index_reg      <= index_next;
      state_reg      <= state_next;
      hold_reg       <= hold_next;
      snapshot_reg   <= snapshot_next;
      anode_reg      <= anode_next;
      digit_code_reg <= digit_code_next;
      frame_tick_reg <= boundary;
    end
  end

  assign bus.alu_gnt    = (state_reg == ST_ALU);
  assign bus.temp_gnt   = (state_reg == ST_TEMP);
  assign bus.anode      = anode_reg;
  assign bus.digit_code = digit_code_reg;
  assign bus.frame_tick = frame_tick_reg;
endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with CLK_DIV=4, HOLD_FRAMES=2.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_display_scheduler;
  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  display_scheduler_if bus ();

  display_scheduler #(
    .CLK_DIV     (4),
    .HOLD_FRAMES (2)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
  endtask

  task automatic wait_frame(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (bus.frame_tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 40'(seen), 40'd1);
  endtask

  task automatic chk_gnt(input string tag, input logic alu, input logic temp);
    chk({tag, "_alu"}, 40'(bus.alu_gnt), 40'(alu));
    chk({tag, "_temp"}, 40'(bus.temp_gnt), 40'(temp));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n        = 1'b0;
    bus.alu_req    = 1'b0;
    bus.temp_req   = 1'b0;
    bus.alu_codes  = '0;
    bus.temp_codes = '0;

    // Reset and single requester: ALU digits 0..7 = 1..8
    for (int k = 0; k < 8; k++) begin
      bus.alu_codes[5*k +: 5]  = 5'(k + 1);
      bus.temp_codes[5*k +: 5] = 5'(16 + k);
    end
    bus.alu_req = 1'b1;
    do_reset();
    step(1);
    chk("rst_anode", 40'(bus.anode), 40'hFF);
    chk_gnt("rst", 1'b0, 1'b0);
    chk("rst_code", 40'(bus.digit_code), 40'd0);
    chk("rst_ft", 40'(bus.frame_tick), 40'd0);
    step(30);
    chk("pre_anode", 40'(bus.anode), 40'hFF);
    chk("pre_ft", 40'(bus.frame_tick), 40'd0);
    chk_gnt("pre", 1'b0, 1'b0);
    step(1);
    chk("first_ft", 40'(bus.frame_tick), 40'd1);
    chk_gnt("first", 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] exp_an;
      exp_an = ~(8'h01 << k);
      chk($sformatf("scan_anode%0d", k), 40'(bus.anode), 40'(exp_an));
      chk($sformatf("scan_code%0d", k), 40'(bus.digit_code), 40'(k + 1));
      step(4);
    end
    chk("scan_wrap_ft", 40'(bus.frame_tick), 40'd1);
    chk("scan_wrap_anode", 40'(bus.anode), 40'hFE);
    $display("phase single requester: checks=%0d", total);

    // Contention, hold and release
    do_reset();
    bus.alu_req  = 1'b1;
    bus.temp_req = 1'b1;
    wait_frame("b0_to");
    chk_gnt("b0", 1'b1, 1'b0);
    wait_frame("b1_to");
    chk_gnt("b1", 1'b1, 1'b0);
    wait_frame("b2_to");
    chk_gnt("b2", 1'b0, 1'b1);
    chk("b2_anode", 40'(bus.anode), 40'hFE);
    chk("b2_code", 40'(bus.digit_code), 40'h10);
    wait_frame("b3_to");
    chk_gnt("b3", 1'b0, 1'b1);
    wait_frame("b4_to");
    chk_gnt("b4", 1'b1, 1'b0);
    chk("b4_code", 40'(bus.digit_code), 40'h01);
    wait_frame("b5_to");
    chk_gnt("b5", 1'b1, 1'b0);
    wait_frame("b6_to");
    chk_gnt("b6", 1'b0, 1'b1);
    bus.alu_req = 1'b0;
    wait_frame("b7_to");
    chk_gnt("b7", 1'b0, 1'b1);
    wait_frame("b8_to");
    chk_gnt("b8", 1'b0, 1'b1);
    bus.temp_req = 1'b0;
    wait_frame("b9_to");
    chk_gnt("b9", 1'b0, 1'b0);
    chk("b9_anode", 40'(bus.anode), 40'hFF);
    chk("b9_code", 40'(bus.digit_code), 40'd0);
    $display("phase contention/release: checks=%0d", total);

    // Mid-frame reset during slot 4 of an ALU frame
    bus.alu_codes[25 +: 5] = 5'h03;
    bus.alu_req = 1'b1;
    wait_frame("mr_to");
    chk_gnt("mr_grant", 1'b1, 1'b0);
    step(16);
    chk("mr_slot4", 40'(bus.anode), 40'hEF);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    chk("mr_anode", 40'(bus.anode), 40'hFF);
    chk_gnt("mr", 1'b0, 1'b0);
    chk("mr_code", 40'(bus.digit_code), 40'd0);
    step(31);
    chk("mr_ft_early", 40'(bus.frame_tick), 40'd0);
    chk("mr_anode_early", 40'(bus.anode), 40'hFF);
    step(1);
    chk("mr_ft", 40'(bus.frame_tick), 40'd1);
    chk_gnt("mr_regrant", 1'b1, 1'b0);
    chk("mr_regrant_anode", 40'(bus.anode), 40'hFE);
    $display("phase mid-frame reset: checks=%0d", total);

    // Tear-free update: digit 5 changes during slot 2
    step(8);
    bus.alu_codes[25 +: 5] = 5'h0B;
    step(12);
    chk("tear_anode", 40'(bus.anode), 40'hDF);
    chk("tear_old", 40'(bus.digit_code), 40'h03);
    step(12);
    chk("tear_ft", 40'(bus.frame_tick), 40'd1);
    step(20);
    chk("tear_anode2", 40'(bus.anode), 40'hDF);
    chk("tear_new", 40'(bus.digit_code), 40'h0B);
    $display("phase tear-free: checks=%0d", total);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
